// File: rtl/scandoubler_ng.sv
// Ping-pong line-buffer scandoubler: each 15 kHz line is replayed twice at 31 kHz, with a registered 15 kHz pass-through.
// Optional: define SCANLINES_EN to add a 'scanline' input that halves rgb during the second replay pass.
module scandoubler_ng #(
  parameter int CBITS = 4,
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dblscan,
  input  logic             in_ce,
  input  logic [CBITS-1:0] red_in,
  input  logic [CBITS-1:0] green_in,
  input  logic [CBITS-1:0] blue_in,
  input  logic             _hsync_in,
  input  logic             _vsync_in,
`ifdef SCANLINES_EN
  input  logic             scanline,
`endif
  output logic [CBITS-1:0] red_out,
  output logic [CBITS-1:0] green_out,
  output logic [CBITS-1:0] blue_out,
  output logic             _hsync_out,
  output logic             _vsync_out,
  output logic             ovf
);

  localparam int WW = 3*CBITS + 1;

  typedef enum logic [1:0] {RD_IDLE, RD_PASS0, RD_PASS1} rd_state_t;

  rd_state_t  rd_state, rd_next;
  logic [AW-1:0] waddr, wlen, raddr, raddr_next, last_addr;
  logic          bank, hsd, vsd, synced;
  logic          sol, vfall, ovf_set;
  logic [AW:0]   widx, ridx;
  logic [WW-1:0] wword, ram_q;
  logic [WW-1:0] mem [2*DEPTH];
  logic          rd_valid, dim;
  logic [CBITS-1:0] r_rd, g_rd, b_rd;

  assign sol       = in_ce & ~_hsync_in & hsd;
  assign vfall     = in_ce & ~_vsync_in & vsd;
  assign ovf_set   = in_ce & ~sol & synced & (waddr == AW'(DEPTH-1));
  assign wword     = {red_in, green_in, blue_in, dblscan ? _hsync_in : (_hsync_in & _vsync_in)};
  assign last_addr = wlen - AW'(1);
  // The sol pixel already goes to the bank being opened; reads always use the other one.
  assign widx      = sol ? {~bank, {AW{1'b0}}} : {bank, waddr};
  assign ridx      = {~bank, raddr};

  // Pixels before the first sol after reset are dropped so that sol reports an empty line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waddr  <= '0;
      wlen   <= '0;
      bank   <= 1'b0;
      hsd    <= 1'b1;
      vsd    <= 1'b1;
      synced <= 1'b0;
      ovf    <= 1'b0;
    end else if (in_ce) begin
      hsd <= _hsync_in;
      vsd <= _vsync_in;
      if (sol) begin
        wlen   <= waddr;
        bank   <= ~bank;
        waddr  <= AW'(1);
        synced <= 1'b1;
      end else if (synced && waddr != AW'(DEPTH-1)) begin
        waddr <= waddr + AW'(1);
      end
      if (ovf_set)
        ovf <= 1'b1;
      else if (vfall)
        ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (in_ce && (sol || synced))
      mem[widx] <= wword;
    ram_q <= mem[ridx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state <= RD_IDLE;
      raddr    <= '0;
    end else begin
      rd_state <= rd_next;
      raddr    <= raddr_next;
    end
  end

  // A new sol restarts the replay even in the middle of a pass.
  always_comb begin
    rd_next    = rd_state;
    raddr_next = raddr;
    if (sol) begin
      raddr_next = '0;
      rd_next    = (waddr != '0) ? RD_PASS0 : RD_IDLE;
    end else if (rd_state != RD_IDLE) begin
      if (raddr == last_addr) begin
        raddr_next = '0;
        rd_next    = (rd_state == RD_PASS0) ? RD_PASS1 : RD_IDLE;
      end else begin
        raddr_next = raddr + AW'(1);
      end
    end
  end

`ifdef SCANLINES_EN
  logic rd_pass;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rd_pass <= 1'b0;
    else
      rd_pass <= (rd_state == RD_PASS1);
  end
  assign dim = scanline & rd_pass;
`else
  assign dim = 1'b0;
`endif

  always_comb begin
    r_rd = ram_q[WW-1 -: CBITS];
    g_rd = ram_q[WW-1-CBITS -: CBITS];
    b_rd = ram_q[CBITS -: CBITS];
    if (dim) begin
      r_rd = r_rd >> 1;
      g_rd = g_rd >> 1;
      b_rd = b_rd >> 1;
    end
  end

  // rd_valid tracks the one-cycle RAM read latency so blanking lines up with the data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid   <= 1'b0;
      red_out    <= '0;
      green_out  <= '0;
      blue_out   <= '0;
      _hsync_out <= 1'b1;
      _vsync_out <= 1'b1;
    end else begin
      rd_valid <= (rd_state != RD_IDLE);
      if (dblscan) begin
        _vsync_out <= _vsync_in;
        if (rd_valid) begin
          red_out    <= r_rd;
          green_out  <= g_rd;
          blue_out   <= b_rd;
          _hsync_out <= ram_q[0];
        end else begin
          red_out    <= '0;
          green_out  <= '0;
          blue_out   <= '0;
          _hsync_out <= 1'b1;
        end
      end else if (in_ce) begin
        red_out    <= red_in;
        green_out  <= green_in;
        blue_out   <= blue_in;
        _hsync_out <= _hsync_in & _vsync_in;
        _vsync_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scandoubler_ng.sv
// Self-checking bench for scandoubler_ng: a line-level replay model checked every cycle, plus literal spot checks.
module tb_scandoubler_ng;

  localparam int CBITS  = 4;
  localparam int DEPTH  = 512;
  localparam int AW     = 9;
  localparam int NL     = 16;
  localparam int MAXPIX = 700;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dblscan = 1'b1;
  logic in_ce = 1'b0;
  logic [3:0] red_in = '0, green_in = '0, blue_in = '0;
  logic _hsync_in = 1'b1, _vsync_in = 1'b1;
`ifdef SCANLINES_EN
  logic scanline = 1'b0;
`endif
  logic [3:0] red_out, green_out, blue_out;
  logic _hsync_out, _vsync_out, ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  scandoubler_ng #(.CBITS(CBITS), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .dblscan(dblscan), .in_ce(in_ce),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    ._hsync_in(_hsync_in), ._vsync_in(_vsync_in),
`ifdef SCANLINES_EN
    .scanline(scanline),
`endif
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    ._hsync_out(_hsync_out), ._vsync_out(_vsync_out), .ovf(ovf)
  );

  // Model: each sol schedules a double replay of the finished line starting two edges later.
  typedef struct { int start; int len; int line; } sched_t;
  sched_t scheds[$];
  logic [12:0] lines [NL][MAXPIX];
  int cyc = 0, cur_line = 0, cnt = 0;
  bit synced = 0, m_hsd = 1, m_vsd = 1, m_ovf = 0, model_on = 0;
  logic [11:0] e_rgb = '0;
  logic e_hs = 1'b1, e_vs = 1'b1;

  function automatic void dbl_word(input int c, output logic [11:0] rgb, output logic hs);
    logic [12:0] w;
    rgb = '0;
    hs  = 1'b1;
    for (int i = scheds.size() - 1; i >= 0; i--) begin
      if (scheds[i].start <= c) begin
        if (scheds[i].len > 0 && (c - scheds[i].start) < 2 * scheds[i].len) begin
          w   = lines[scheds[i].line][(c - scheds[i].start) % scheds[i].len];
          rgb = w[12:1];
          hs  = w[0];
        end
        break;
      end
    end
  endfunction

  always @(posedge clk) begin : model_p
    bit sol, clr, setf;
    int l;
    logic [12:0] w;
    if (reset) begin
      scheds.delete();
      synced = 0; m_hsd = 1; m_vsd = 1; m_ovf = 0; cnt = 0;
      e_rgb = '0; e_hs = 1'b1; e_vs = 1'b1; model_on = 1;
    end else begin
      sol = in_ce && !_hsync_in && m_hsd;
      if (dblscan) begin
        dbl_word(cyc, e_rgb, e_hs);
        e_vs = _vsync_in;
      end else if (in_ce) begin
        e_rgb = {red_in, green_in, blue_in};
        e_hs  = _hsync_in & _vsync_in;
        e_vs  = 1'b1;
      end
      if (in_ce) begin
        w = {red_in, green_in, blue_in, dblscan ? _hsync_in : (_hsync_in & _vsync_in)};
        setf = 0;
        if (sol) begin
          l = synced ? ((cnt < DEPTH - 1) ? cnt : DEPTH - 1) : 0;
          scheds.push_back('{start: cyc + 2, len: l, line: cur_line});
          cur_line = (cur_line + 1) % NL;
          lines[cur_line][0] = w;
          cnt = 1;
          synced = 1;
        end else if (synced) begin
          if (cnt < MAXPIX) lines[cur_line][cnt] = w;
          setf = (cnt >= DEPTH - 1);
          cnt++;
        end
        clr = !_vsync_in && m_vsd;
        if (setf) m_ovf = 1;
        else if (clr) m_ovf = 0;
        m_hsd = _hsync_in;
        m_vsd = _vsync_in;
      end
    end
    cyc++;
  end

  always @(posedge clk) begin
    #2;
    if (model_on) begin
      checks++;
      if ({red_out, green_out, blue_out, _hsync_out, _vsync_out, ovf} !== {e_rgb, e_hs, e_vs, m_ovf}) begin
        errors++;
        $display("[TB] FAIL model cycle %0d: got rgb=%h hs=%b vs=%b ovf=%b, want rgb=%h hs=%b vs=%b ovf=%b",
                 cyc, {red_out, green_out, blue_out}, _hsync_out, _vsync_out, ovf, e_rgb, e_hs, e_vs, m_ovf);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [11:0] rgb, input logic hs, input logic vs, input logic ov);
    checks++;
    if ({red_out, green_out, blue_out, _hsync_out, _vsync_out, ovf} !== {rgb, hs, vs, ov}) begin
      errors++;
      $display("[TB] FAIL %s: got rgb=%h hs=%b vs=%b ovf=%b, want rgb=%h hs=%b vs=%b ovf=%b",
               name, {red_out, green_out, blue_out}, _hsync_out, _vsync_out, ovf, rgb, hs, vs, ov);
    end
  endtask

  task automatic checkOvf(input string name, input logic want);
    checks++;
    if (ovf !== want) begin
      errors++;
      $display("[TB] FAIL %s: got ovf=%b, want ovf=%b", name, ovf, want);
    end
  endtask

  // One input pixel: in_ce high for one clk, low for the next.
  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                               input logic hs, input logic vs);
    red_in = r; green_in = g; blue_in = b;
    _hsync_in = hs; _vsync_in = vs;
    in_ce = 1'b1;
    @(negedge clk);
    in_ce = 1'b0;
    @(negedge clk);
  endtask

  task automatic sendLine(input int n, input int hlow, input logic vs);
    for (int i = 0; i < n; i++)
      applyStimulus(4'(i % 16), 4'((i + 5) % 16), 4'(15 - i % 16), (i >= hlow), vs);
  endtask

  task automatic checkAt(input int k, input string name, input logic [11:0] rgb, input logic hs,
                         input logic vs, input logic ov);
    fork
      begin
        repeat (k) @(negedge clk);
        checkOutput(name, rgb, hs, vs, ov);
      end
    join_none
  endtask

  initial begin
    $display("[TB] scandoubler_ng bench start");
    repeat (3) @(negedge clk);
    checkOutput("reset_state", 12'h000, 1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("idle_after_reset", 12'h000, 1'b1, 1'b1, 1'b0);

    // First sol after reset carries an empty line, so output stays blank.
    checkAt(3, "first_sol_blank", 12'h000, 1'b1, 1'b1, 1'b0);
    sendLine(454, 32, 1'b1);

    checkAt(3,   "pass0_px0",   12'h05F, 1'b0, 1'b1, 1'b0);
    checkAt(8,   "pass0_px5",   12'h5AA, 1'b0, 1'b1, 1'b0);
    checkAt(43,  "pass0_px40",  12'h8D7, 1'b1, 1'b1, 1'b0);
    checkAt(462, "pass1_px5",   12'h5AA, 1'b0, 1'b1, 1'b0);
    checkAt(910, "pass1_px453", 12'h5AA, 1'b1, 1'b1, 1'b0);
    sendLine(454, 32, 1'b1);

    // Overlong line saturates the write address and sets ovf.
    sendLine(600, 32, 1'b1);
    checkOvf("ovf_set_after_600", 1'b1);
    sendLine(454, 32, 1'b1);
    checkOvf("ovf_held", 1'b1);
    applyStimulus(4'h0, 4'h5, 4'hF, 1'b0, 1'b0);
    checkOvf("ovf_cleared_by_vsync", 1'b0);
    sendLine(453, 32, 1'b0);

    // Short line truncates the second pass of the previous replay.
    sendLine(454, 32, 1'b1);
    sendLine(300, 32, 1'b1);
    checkAt(2, "trunc_old_px145", 12'h16E, 1'b1, 1'b1, 1'b0);
    checkAt(3, "trunc_new_px0",   12'h05F, 1'b0, 1'b1, 1'b0);
    sendLine(454, 32, 1'b1);

    // Pass-through: registered on in_ce, composite sync, vsync held high.
    dblscan = 1'b0;
    @(negedge clk);
    red_in = 4'h5; green_in = 4'hA; blue_in = 4'hF;
    _hsync_in = 1'b1; _vsync_in = 1'b0; in_ce = 1'b1;
    @(negedge clk);
    checkOutput("passthru_pixel", 12'h5AF, 1'b0, 1'b1, 1'b0);
    in_ce = 1'b0;
    red_in = 4'h3; green_in = 4'h3; blue_in = 4'h3;
    @(negedge clk);
    checkOutput("passthru_hold", 12'h5AF, 1'b0, 1'b1, 1'b0);
    sendLine(40, 10, 1'b1);
    sendLine(40, 10, 1'b1);

    // Back to scandoubling, then reset in the middle of a line.
    dblscan = 1'b1;
    sendLine(200, 32, 1'b1);
    sendLine(100, 32, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) applyStimulus(4'h9, 4'h9, 4'h9, 1'b1, 1'b1);
    checkAt(3, "post_reset_first_sol_blank", 12'h000, 1'b1, 1'b1, 1'b0);
    sendLine(300, 32, 1'b1);
    checkAt(3, "post_reset_replay_px0", 12'h05F, 1'b0, 1'b1, 1'b0);
    sendLine(300, 32, 1'b1);
    sendLine(20, 5, 1'b1);
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
